alu_exec_unit: RTL

Execute-stage ALU that consumes the 4-bit operation code produced by the ALU control decoder, together with two register/immediate operands. It produces a registered result and branch flags under a valid/ready handshake. Add, sub, compare and logic ops complete in one cycle. Shifts run on an iterative 1-bit-per-cycle shifter to save area. The block sits between the ID/EX operand latch (upstream) and writeback/branch resolution (downstream).

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_shifter.sv | 63 ++++++
 rtl/alu_exec_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the control decoder and the
// execute unit, plus the execute-unit FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] ctl);
        return (ctl == ALU_SLL) || (ctl == ALU_SRL) || (ctl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative shifter: moves the working register one bit per cycle until the
// loaded count is exhausted; done is high in the cycle of the final step.
module alu_shifter #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] op_a,
    input  logic [SHW-1:0]  shamt,
    input  logic            dir,
    input  logic            arith,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] value
);

    logic [XLEN-1:0] work_q, work_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            dir_q, dir_d;
    logic            arith_q, arith_d;
    logic [XLEN-1:0] shifted;

    // dir = 1 shifts right; arith replicates the sign bit on right shifts
    assign shifted = dir_q ? {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]}
                           : {work_q[XLEN-2:0], 1'b0};

    assign busy  = (cnt_q != '0);
    assign done  = (cnt_q == SHW'(1));
    assign value = shifted;

    always_comb begin
        work_d  = work_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        if (start) begin
            work_d  = op_a;
            cnt_d   = shamt;
            dir_d   = dir;
            arith_d = arith;
        end else if (busy) begin
            work_d = shifted;
            cnt_d  = cnt_q - SHW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops, iterative shifts, with
// registered result and flags held under a valid/ready output handshake.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            lt,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    state_t          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            lt_q, lt_d;
    logic            illegal_q, illegal_d;

    logic [SHW-1:0]  shamt;
    logic            accept;
    logic            sh_start;
    logic            sh_busy;
    logic            sh_done;
    logic [XLEN-1:0] sh_value;
    logic            lt_calc;
    logic            legal;
    logic [XLEN-1:0] alu_res;

    assign shamt    = op_b[SHW-1:0];
    assign lt_calc  = $signed(op_a) < $signed(op_b);
    assign in_ready = (state_q == IDLE) && !sh_busy && (!out_valid_q || out_ready) && !reset;
    assign accept   = in_valid && in_ready;
    assign sh_start = accept && is_shift_op(alu_ctl) && (shamt != '0);

    // Shifts by zero fall through here as a single-cycle pass of op_a
    always_comb begin
        alu_res = '0;
        legal   = 1'b1;
        case (alu_ctl)
            ALU_ADD:   alu_res = op_a + op_b;
            ALU_SUB:   alu_res = op_a - op_b;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, lt_calc};
            ALU_OR:    alu_res = op_a | op_b;
            ALU_AND:   alu_res = op_a & op_b;
            ALU_XOR:   alu_res = op_a ^ op_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:   alu_res = op_a;
            ALU_PASSB: alu_res = op_b;
            default: begin
                alu_res = '0;
                legal   = 1'b0;
            end
        endcase
    end

    alu_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shifter (
        .clk   (clk),
        .reset (reset),
        .start (sh_start),
        .op_a  (op_a),
        .shamt (shamt),
        .dir   (alu_ctl != ALU_SLL),
        .arith (alu_ctl == ALU_SRA),
        .busy  (sh_busy),
        .done  (sh_done),
        .value (sh_value)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        lt_d        = lt_q;
        illegal_d   = illegal_q;
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (state_q == IDLE) begin
            // An accept implies the old result is consumed this edge, so
            // overwriting the flags here never disturbs a held output.
            if (sh_start) begin
                state_d   = SHIFT;
                lt_d      = lt_calc;
                illegal_d = 1'b0;
            end else if (accept) begin
                result_d    = alu_res;
                zero_d      = (alu_res == '0);
                lt_d        = lt_calc;
                illegal_d   = !legal;
                out_valid_d = 1'b1;
            end
        end else if (sh_done) begin
            state_d     = IDLE;
            result_d    = sh_value;
            zero_d      = (sh_value == '0);
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            lt_q        <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            lt_q        <= lt_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign lt        = lt_q;
    assign illegal   = illegal_q;

endmodule
